// File: rtl/sum_stream_if.sv
// Handshake bundle for the running-sum decoder: sum-byte input stream on one
// side, decoded-byte output stream (with borrow flag) on the other.
interface sum_stream_if #(
   parameter int W = 8
);
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_data;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_data;
   logic         out_borrow;

   // Producer of sums / consumer of decoded bytes
   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_borrow
   );

   // The decoder itself
   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_borrow
   );
endinterface

// File: rtl/sum_stream_decoder.sv
// Running-sum stream decoder: d_k = s_k - s_(k-1) mod 2^W, with borrow flag,
// buffered in a small output FIFO drained over valid/ready.
// clr re-zeroes the predecessor (stream resync) without touching the FIFO.
module sum_stream_decoder #(
   parameter int W     = 8,
   parameter int DEPTH = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   sum_stream_if.slave      bus,
   output logic [CNT_W-1:0] sample_cnt,
   output logic             empty,
   output logic             full
);
   localparam int             AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [AW:0]    OCC_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0]  PTR_ONE  = AW'(1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [W-1:0]     prev;
   logic [W-1:0]     base;
   logic [W-1:0]     diff;
   logic             borrow;
   logic [W-1:0]     mem_d [DEPTH];
   logic [DEPTH-1:0] mem_b;
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic [AW:0]      count;
   logic             push;
   logic             pop;

   // Status, handshake and decode arithmetic; head is masked to 0 while empty
   always_comb begin
      empty          = (count == '0);
      full           = (count == FULL_CNT);
      bus.in_ready   = !full;
      bus.out_valid  = !empty;
      push           = bus.in_valid & !full;
      pop            = !empty & bus.out_ready;
      base           = clr ? '0 : prev;
      diff           = bus.in_data - base;
      borrow         = (bus.in_data < base);
      bus.out_data   = empty ? '0 : mem_d[rd_ptr];
      bus.out_borrow = empty ? 1'b0 : mem_b[rd_ptr];
   end

   // FIFO storage write; stale entries never reach the outputs (masked above)
   always_ff @(posedge clk) begin
      if (!rst && push) begin
         mem_d[wr_ptr] <= diff;
         mem_b[wr_ptr] <= borrow;
      end
   end

   // Pointers, occupancy, predecessor and sample counter
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         count      <= '0;
         prev       <= '0;
         sample_cnt <= '0;
      end else begin
         if (push) begin
            wr_ptr     <= wr_ptr + PTR_ONE;
            prev       <= bus.in_data;
            sample_cnt <= sample_cnt + CNT_ONE;
         end else if (clr) begin
            prev <= '0;
         end
         if (pop) rd_ptr <= rd_ptr + PTR_ONE;
         case ({push, pop})
            2'b10:   count <= count + OCC_ONE;
            2'b01:   count <= count - OCC_ONE;
            default: count <= count;
         endcase
      end
   end
endmodule

// File: tb/tb_sum_stream_decoder.sv
// Self-checking bench for sum_stream_decoder: queue-based reference model,
// per-cycle compare process, directed scenarios plus a randomized run.
module tb_sum_stream_decoder;
   localparam int W     = 8;
   localparam int DEPTH = 4;
   localparam int CNT_W = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             clr;
   logic [CNT_W-1:0] sample_cnt;
   logic             empty;
   logic             full;

   sum_stream_if #(.W(W)) bus ();

   sum_stream_decoder #(.W(W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .clr        (clr),
      .bus        (bus),
      .sample_cnt (sample_cnt),
      .empty      (empty),
      .full       (full)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   bit chk_en = 1'b0;

   // Reference model state: queue of {d, borrow}, predecessor, counter
   logic [W:0]       mq [$];
   logic [W-1:0]     m_prev;
   logic [CNT_W-1:0] m_cnt;
   logic [W:0]       obs [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: acts on the same edge as the DUT using the inputs held stable there
   always @(posedge clk) begin
      logic         acc;
      logic         pp;
      logic [W-1:0] b;
      logic [W-1:0] dd;
      if (rst) begin
         mq.delete();
         m_prev = '0;
         m_cnt  = '0;
      end else begin
         acc = bus.in_valid && (mq.size() < DEPTH);
         pp  = (mq.size() > 0) && bus.out_ready;
         b   = clr ? '0 : m_prev;
         if (pp) void'(mq.pop_front());
         if (acc) begin
            dd = bus.in_data - b;
            mq.push_back({dd, (bus.in_data < b)});
            m_prev = bus.in_data;
            m_cnt  = m_cnt + 1'b1;
         end else if (clr) begin
            m_prev = '0;
         end
      end
   end

   // Compare process: every cycle, away from the active edge
   always @(negedge clk) begin
      if (chk_en) begin
         chk("in_ready",   32'(bus.in_ready),  32'(mq.size() < DEPTH));
         chk("full",       32'(full),          32'(mq.size() == DEPTH));
         chk("empty",      32'(empty),         32'(mq.size() == 0));
         chk("out_valid",  32'(bus.out_valid), 32'(mq.size() != 0));
         chk("sample_cnt", 32'(sample_cnt),    32'(m_cnt));
         chk("out_data",   32'(bus.out_data),   (mq.size() != 0) ? 32'(mq[0][W:1]) : 32'h0);
         chk("out_borrow", 32'(bus.out_borrow), (mq.size() != 0) ? 32'(mq[0][0])   : 32'h0);
         if (bus.out_valid && bus.out_ready) obs.push_back({bus.out_data, bus.out_borrow});
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   // Offer one sum until accepted (bounded); optionally jitter out_ready
   task automatic send(input logic [W-1:0] v, input logic c, input bit rnd);
      bit done = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_data  = v;
      clr          = c;
      for (int n = 0; n < 200 && !done; n++) begin
         @(negedge clk);
         if (bus.in_ready) done = 1'b1;
         @(posedge clk); #1;
         if (rnd) bus.out_ready = 1'($urandom_range(0, 1));
      end
      bus.in_valid = 1'b0;
      clr          = 1'b0;
      bus.in_data  = W'($urandom);
      if (!done) begin
         tests++;
         fails++;
         $display("FAIL send_timeout: got no accept expected accept of 0x%0h", v);
      end
   endtask

   task automatic chk_obs(input string name, input logic [W:0] exp [$]);
      chk({name, "_count"}, 32'(obs.size()), 32'(exp.size()));
      for (int i = 0; i < exp.size() && i < obs.size(); i++)
         chk(name, 32'(obs[i]), 32'(exp[i]));
   endtask

   initial begin
      logic [W:0] e [$];
      rst = 1'b1; clr = 1'b0;
      bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_en = 1'b1;
      @(negedge clk);
      chk("rst_empty",     32'(empty),          32'h1);
      chk("rst_full",      32'(full),           32'h0);
      chk("rst_in_ready",  32'(bus.in_ready),   32'h1);
      chk("rst_out_valid", 32'(bus.out_valid),  32'h0);
      chk("rst_cnt",       32'(sample_cnt),     32'h0);
      chk("rst_data",      32'(bus.out_data),   32'h0);
      chk("rst_borrow",    32'(bus.out_borrow), 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Basic decode with one-cycle latency
      bus.out_ready = 1'b1;
      obs.delete();
      send(8'h05, 1'b0, 1'b0);
      @(negedge clk);
      chk("latency_valid", 32'(bus.out_valid), 32'h1);
      chk("latency_data",  32'(bus.out_data),  32'h05);
      @(posedge clk); #1;
      send(8'h0C, 1'b0, 1'b0);
      send(8'h20, 1'b0, 1'b0);
      idle(3);
      e = '{{8'h05, 1'b0}, {8'h07, 1'b0}, {8'h14, 1'b0}};
      chk_obs("basic", e);
      chk("basic_cnt", 32'(sample_cnt), 32'd3);

      // Wrap-around subtraction with borrow (resync first so prev = 0)
      obs.delete();
      send(8'hF0, 1'b1, 1'b0);
      send(8'h10, 1'b0, 1'b0);
      idle(3);
      e = '{{8'hF0, 1'b0}, {8'h20, 1'b1}};
      chk_obs("wrap", e);

      // Backpressure: 4 fit, 5th held while full, then drain
      bus.out_ready = 1'b0;
      obs.delete();
      send(8'h10, 1'b1, 1'b0);
      send(8'h30, 1'b0, 1'b0);
      send(8'h20, 1'b0, 1'b0);
      send(8'h80, 1'b0, 1'b0);
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h81;
      idle(3);
      @(negedge clk);
      chk("bp_full",     32'(full),         32'h1);
      chk("bp_in_ready", 32'(bus.in_ready), 32'h0);
      chk("bp_cnt",      32'(sample_cnt),   32'd9);
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
      send(8'h81, 1'b0, 1'b0);
      send(8'h01, 1'b0, 1'b0);
      idle(8);
      e = '{{8'h10, 1'b0}, {8'h20, 1'b0}, {8'hF0, 1'b1},
            {8'h60, 1'b0}, {8'h01, 1'b0}, {8'h80, 1'b1}};
      chk_obs("backpressure", e);
      chk("bp_cnt_end", 32'(sample_cnt), 32'd11);

      // clr in the same cycle as an accept decodes against 0
      obs.delete();
      send(8'h30, 1'b1, 1'b0);
      send(8'h35, 1'b1, 1'b0);
      send(8'h40, 1'b0, 1'b0);
      idle(3);
      e = '{{8'h30, 1'b0}, {8'h35, 1'b0}, {8'h0B, 1'b0}};
      chk_obs("clr", e);

      // Simultaneous push/pop at occupancy 2
      obs.delete();
      bus.out_ready = 1'b0;
      send(W'($urandom), 1'b0, 1'b0);
      send(W'($urandom), 1'b0, 1'b0);
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      for (int i = 0; i < 10; i++) begin
         bus.in_data = W'($urandom);
         @(negedge clk);
         chk("pp_valid", 32'(bus.out_valid), 32'h1);
         chk("pp_full",  32'(full),          32'h0);
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
      idle(4);
      chk("pp_popped", 32'(obs.size()), 32'd12);
      chk("pp_cnt",    32'(sample_cnt), 32'd26);

      // Randomized: 256 accepts with jittered ready, gaps and clr; count wraps
      for (int i = 0; i < 256; i++) begin
         if ($urandom_range(0, 3) == 0) idle(1);
         send(W'($urandom), 1'($urandom_range(0, 7) == 0), 1'b1);
      end
      bus.out_ready = 1'b1;
      idle(8);
      chk("cnt_wrap",  32'(sample_cnt), 32'd26);
      chk("rnd_empty", 32'(empty),      32'h1);

      // Mid-stream reset with the FIFO full
      bus.out_ready = 1'b0;
      repeat (4) send(W'($urandom), 1'b0, 1'b0);
      @(negedge clk);
      chk("pre_rst_full", 32'(full), 32'h1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("mrst_empty", 32'(empty),         32'h1);
      chk("mrst_valid", 32'(bus.out_valid), 32'h0);
      chk("mrst_cnt",   32'(sample_cnt),    32'h0);
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
      obs.delete();
      send(8'h07, 1'b0, 1'b0);
      idle(3);
      e = '{{8'h07, 1'b0}};
      chk_obs("post_rst", e);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
